// File: rtl/divider.sv
// Sequential radix-2 restoring divider, one quotient bit per clock, signed or unsigned.
// Operands and results move through valid/ready handshakes; outputs are registered.
module divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             init_q, init_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] x_mag, y_mag;
  logic [WIDTH:0]   shifted, trial;
  logic             dbz;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StCalc;
      StCalc: if (!init_q && (cnt_q == '0)) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready    = (state_q == StIdle);
    out_valid   = (state_q == StDone);
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = dbz_q;
  end

  // Magnitudes of the captured operands; |-2^(WIDTH-1)| wraps to itself, which is exact unsigned
  assign x_mag = (sgn_q && x_q[WIDTH-1]) ? (~x_q + 1'b1) : x_q;
  assign y_mag = (sgn_q && y_q[WIDTH-1]) ? (~y_q + 1'b1) : y_q;

  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dmag_q};
  assign dbz     = (dmag_q == '0);

  // Datapath next-state
  always_comb begin
    cnt_d       = cnt_q;
    init_d      = init_q;
    x_d         = x_q;
    y_d         = y_q;
    sgn_d       = sgn_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dmag_d      = dmag_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d    = X;
          y_d    = Y;
          sgn_d  = is_signed;
          init_d = 1'b1;
          cnt_d  = CntW'(WIDTH - 1);
        end
      end
      StCalc: begin
        // First cycle after accept only prepares magnitudes, keeping inputs off the adder path
        if (init_q) begin
          init_d  = 1'b0;
          rem_d   = '0;
          quo_d   = x_mag;
          dmag_d  = y_mag;
          q_neg_d = sgn_q && (x_q[WIDTH-1] ^ y_q[WIDTH-1]);
          r_neg_d = sgn_q && x_q[WIDTH-1];
        end else begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
          end else begin
            rem_d = shifted[WIDTH-1:0];
          end
          quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        dbz_d = dbz;
        if (dbz) begin
          quotient_d  = '1;
          remainder_d = x_q;
        end else begin
          quotient_d  = q_neg_q ? (~quo_q + 1'b1) : quo_q;
          remainder_d = r_neg_q ? (~rem_q + 1'b1) : rem_q;
        end
      end
      StDone: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q       <= '0;
      init_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      sgn_q       <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dmag_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      init_q      <= init_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sgn_q       <= sgn_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dmag_q      <= dmag_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

endmodule

// File: tb/tb_divider.sv
// Randomized self-checking bench for divider against an arithmetic reference model.
module tb_divider;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned LAT   = WIDTH + 2;

  logic             clk;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .is_signed  (is_signed),
    .X          (X),
    .Y          (Y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division with truncation toward zero, plus the zero-divisor rule
  function automatic void model(input logic [31:0] x, input logic [31:0] y, input logic s,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic z);
    longint          xs, ys;
    longint unsigned xu, yu;
    if (y == 0) begin
      q = 32'hFFFF_FFFF;
      r = x;
      z = 1'b1;
    end else if (s) begin
      xs = longint'($signed(x));
      ys = longint'($signed(y));
      q  = 32'(xs / ys);
      r  = 32'(xs % ys);
      z  = 1'b0;
    end else begin
      xu = 64'(x);
      yu = 64'(y);
      q  = 32'(xu / yu);
      r  = 32'(xu % yu);
      z  = 1'b0;
    end
  endfunction

  // Present one operation, return cycles from accept edge until out_valid is seen
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        output int lat);
    @(posedge clk);
    #1;
    check_eq("in_ready_before_accept", 64'(in_ready), 64'd1);
    X         = x;
    Y         = y;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    X        = $urandom;
    Y        = $urandom;
    lat      = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("out_valid_after_hs", 64'(out_valid), 64'd0);
    check_eq("in_ready_after_hs", 64'(in_ready), 64'd1);
  endtask

  task automatic op_check(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic s);
    logic [31:0] eq, er;
    logic        ez;
    int          lat;
    model(x, y, s, eq, er, ez);
    run_op(x, y, s, lat);
    check_eq({tag, "_lat"}, 64'(lat), 64'(LAT));
    check_eq({tag, "_q"}, 64'(quotient), 64'(eq));
    check_eq({tag, "_r"}, 64'(remainder), 64'(er));
    check_eq({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
    finish_op();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] eq, er, xr, yr;
    logic        ez, sr;
    int          lat;

    resetn    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    is_signed = 1'b0;
    X         = '0;
    Y         = '0;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_q", 64'(quotient), 64'd0);
    check_eq("rst_r", 64'(remainder), 64'd0);
    check_eq("rst_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    op_check("u100_7", 32'd100, 32'd7, 1'b0);
    op_check("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
    op_check("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
    op_check("u_dbz", 32'h1234_5678, 32'd0, 1'b0);
    op_check("s_dbz", 32'h1234_5678, 32'd0, 1'b1);
    op_check("s_dbz_neg", 32'h8000_0005, 32'd0, 1'b1);
    op_check("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    op_check("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    op_check("s_m8_m3", 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1'b1);
    op_check("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0);

    // Stalled consumer: result must hold and new operands must be ignored
    model(32'd1000, 32'd33, 1'b0, eq, er, ez);
    run_op(32'd1000, 32'd33, 1'b0, lat);
    check_eq("stall_lat", 64'(lat), 64'(LAT));
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      X        = 32'd77;
      Y        = 32'd5;
      @(posedge clk);
      #1;
      check_eq("stall_valid", 64'(out_valid), 64'd1);
      check_eq("stall_q", 64'(quotient), 64'(eq));
      check_eq("stall_r", 64'(remainder), 64'(er));
      check_eq("stall_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    finish_op();

    // out_ready held high throughout: result still appears at the fixed latency
    model(32'hFFFF_FC18, 32'd10, 1'b1, eq, er, ez);
    out_ready = 1'b1;
    run_op(32'hFFFF_FC18, 32'd10, 1'b1, lat);
    check_eq("early_rdy_lat", 64'(lat), 64'(LAT));
    check_eq("early_rdy_q", 64'(quotient), 64'(eq));
    check_eq("early_rdy_r", 64'(remainder), 64'(er));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("early_rdy_drop", 64'(out_valid), 64'd0);
    check_eq("early_rdy_idle", 64'(in_ready), 64'd1);

    // Reset mid-operation
    @(posedge clk);
    #1;
    X         = 32'd12345;
    Y         = 32'd67;
    is_signed = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check_eq("midrst_in_ready", 64'(in_ready), 64'd1);
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_q", 64'(quotient), 64'd0);
    check_eq("midrst_r", 64'(remainder), 64'd0);
    check_eq("midrst_dbz", 64'(div_by_zero), 64'd0);
    #2;
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("midrst_no_result", 64'(out_valid), 64'd0);
    op_check("after_rst", 32'd12345, 32'd67, 1'b0);

    for (int n = 0; n < 40; n++) begin
      xr = $urandom;
      sr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: yr = $urandom;
        1: yr = 32'($urandom_range(1, 15));
        2: yr = 32'(-$urandom_range(1, 300));
        3: yr = $urandom >> $urandom_range(1, 31);
        default: yr = 32'd0;
      endcase
      op_check("rand", xr, yr, sr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
